shift_sub_divider: RTL and testbench

Sequential unsigned restoring divider, SIZE-bit dividend by SIZE-bit divisor, one quotient bit per clock. It is the inverse companion of the team's shift-add multiplier and sits in the same arithmetic block set. A start/busy/done handshake makes it usable as a multi-cycle datapath unit. Quotient and remainder are registered and held until the next result.

---
 rtl/arith_pkg.sv | 17 +
 rtl/div_step.sv | 26 ++
 rtl/shift_sub_divider.sv | 100 ++++++++++
 tb/tb_shift_sub_divider.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic block-set definitions: FSM encodings, default operand
// width and iteration counter sizing for the sequential divider.
package arith_pkg;

    localparam int DIV_SIZE = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_SIZE);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step
    import arith_pkg::*;
#(
    parameter int SIZE = DIV_SIZE
) (
    input  logic [SIZE-1:0] rem,
    input  logic            dvd_bit,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE-1:0] rem_next,
    output logic            q_bit
);

    logic [SIZE:0] trial;
    logic [SIZE:0] diff;

    always_comb begin
        trial = {rem, dvd_bit};
        diff  = trial - {1'b0, divisor};
        q_bit = (trial >= {1'b0, divisor});
        // On a failed trial, trial < divisor, so its MSB is already clear.
        rem_next = q_bit ? diff[SIZE-1:0] : trial[SIZE-1:0];
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Optional macro: DIV_ZERO_BYPASS_EN.
module shift_sub_divider
    import arith_pkg::*;
#(
    parameter int SIZE = DIV_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CNT_W = cnt_width(SIZE);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [SIZE-1:0]  dvd;
    logic [SIZE-1:0]  dsr;
    // Partial remainder MSB is always 0 between iterations, so only the low
    // SIZE bits are stored; div_step rebuilds the SIZE+1 bit trial value.
    logic [SIZE-1:0]  rem;
    logic [SIZE-1:0]  quo;
    logic [SIZE-1:0]  rem_next;
    logic             q_bit;

    div_step #(.SIZE(SIZE)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd[SIZE-1]),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            quo         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd <= dividend;
                        dsr <= divisor;
                        rem <= '0;
                        quo <= '0;
                        cnt <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                        // Preload the result the iterations would produce.
                        if (divisor == '0) begin
                            quo   <= '1;
                            rem   <= dividend;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    dvd <= {dvd[SIZE-2:0], 1'b0};
                    quo <= {quo[SIZE-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(SIZE - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    quotient    <= quo;
                    remainder   <= rem;
                    div_by_zero <= (dsr == '0);
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: latency-level reference model
// checked every cycle, plus directed literal cases and a random sweep.
module tb_shift_sub_divider;

    localparam int SIZE = 8;
`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [SIZE-1:0] dividend = '0;
    logic [SIZE-1:0] divisor = '0;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            div_by_zero;

    int tests = 0;
    int fails = 0;

    shift_sub_divider #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Result as {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [2*SIZE:0] ref_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        if (b == 0) return {1'b1, {SIZE{1'b1}}, a};
        return {1'b0, SIZE'(a / b), SIZE'(a % b)};
    endfunction

    // Model: an accepted operation finishes a fixed number of edges later.
    int              m_left = 0;
    logic [2*SIZE:0] m_pend = '0;
    logic [2*SIZE:0] m_res = '0;
    logic            m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left <= 0;
            m_res  <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_res  <= m_pend;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_pend <= ref_div(dividend, divisor);
                m_left <= (BYP && divisor == 0) ? 1 : SIZE + 1;
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if ({busy, done, div_by_zero, quotient, remainder} !== {(m_left != 0), m_done, m_res}) begin
            fails++;
            $display("FAIL cycle t=%0t dut busy=%b done=%b dz=%b q=%0d r=%0d expected busy=%b done=%b dz=%b q=%0d r=%0d",
                     $time, busy, done, div_by_zero, quotient, remainder,
                     (m_left != 0), m_done, m_res[2*SIZE], m_res[2*SIZE-1:SIZE], m_res[SIZE-1:0]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    // Launch one operation and check its result, latency and busy length.
    task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [SIZE-1:0] eq, input logic [SIZE-1:0] er,
                          input logic edz, input string nm);
        int n = 0;
        int nb = 0;
        bit seen = 0;
        int lat = (BYP && b == 0) ? 2 : SIZE + 2;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else if (busy) nb++;
            #1;
            start    = 1'b0;
            dividend = SIZE'($urandom);
            divisor  = SIZE'($urandom);
        end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_busy_len"}, nb, lat - 1);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_dz"}, div_by_zero, edz);
    endtask

    initial begin
        int n;
        int nd;
        int last;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [2*SIZE:0] r;

        #1 rst = 1'b0;
        idle(2);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        chk("reset_dz", div_by_zero, 0);
        rst = 1'b1;
        idle(2);

        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "100_7");
        idle(3);
        chk("hold_q", quotient, 14);
        chk("hold_r", remainder, 2);
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "255_1");
        run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, "5_9");
        run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, "255_255");
        run_op(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, "0_3");
        run_op(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, "200_0");
        run_op(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, "50_5");

        // Start pulse during CALC must be dropped.
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        nd = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (done) nd++;
            #1;
            start = (i == 2);
            if (i == 2) begin dividend = 8'd9; divisor = 8'd3; end
        end
        chk("ignored_start_dones", nd, 1);
        chk("ignored_start_q", quotient, 14);
        chk("ignored_start_r", remainder, 2);

        // Reset after E4 aborts the operation.
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            #1 start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        #1 rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        #1;
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "after_abort");

        // Start held high: acceptances every SIZE+2 edges.
        start = 1'b1;
        dividend = SIZE'($urandom);
        divisor  = SIZE'($urandom_range(1, 255));
        nd = 0;
        last = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("held_done_spacing", i - last, SIZE + 2);
                last = i;
            end
            #1;
            dividend = SIZE'($urandom);
            divisor  = SIZE'($urandom_range(1, 255));
        end
        start = 1'b0;
        chk("held_done_count", nd, 3);
        idle(15);

        // Random sweep against / and %, including zero divisors.
        for (int k = 0; k < 150; k++) begin
            a = SIZE'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : SIZE'($urandom);
            r = ref_div(a, b);
            run_op(a, b, r[2*SIZE-1:SIZE], r[SIZE-1:0], r[2*SIZE], "rand");
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
